// File: rtl/axis_pack_fifo.sv
// Narrow-in / wide-out AXIS FIFO: packs OUT_MUX samples LSB-first per beat, tlast closes short beats.
// Define AXIS_PACK_FIFO_LEVEL_EN to add the registered m_axis_out_tlevel occupancy port.
module axis_pack_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned OUT_MUX    = 4,
    parameter int unsigned FIFO_LEN   = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [DATA_WIDTH-1:0]            s_axis_in_tdata,
    input  logic [USER_WIDTH-1:0]            s_axis_in_tuser,
    input  logic                             s_axis_in_tlast,
    input  logic                             s_axis_in_tvalid,
    output logic                             s_axis_in_tready,
    output logic [DATA_WIDTH*OUT_MUX-1:0]    m_axis_out_tdata,
    output logic [USER_WIDTH*OUT_MUX-1:0]    m_axis_out_tuser,
    output logic [OUT_MUX-1:0]               m_axis_out_tkeep,
    output logic                             m_axis_out_tlast,
    output logic                             m_axis_out_tvalid,
    input  logic                             m_axis_out_tready,
    output logic                             m_axis_out_tempty
`ifdef AXIS_PACK_FIFO_LEVEL_EN
    ,
    output logic [$clog2(FIFO_LEN):0]        m_axis_out_tlevel
`endif
);
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_LEN);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    typedef logic [CNT_WIDTH-1:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_LEN];
    logic [USER_WIDTH-1:0] mem_user [FIFO_LEN];
    logic [FIFO_LEN-1:0]   mem_last;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t last_cnt_q, last_cnt_d;
    ptr_t count, beat_len;
    logic full, wr_en, beat_avail, load, found;
    logic [PTR_WIDTH-1:0] rd_addr;

    logic [DATA_WIDTH*OUT_MUX-1:0] beat_data, tdata_q;
    logic [USER_WIDTH*OUT_MUX-1:0] beat_user, tuser_q;
    logic [OUT_MUX-1:0]            beat_keep, tkeep_q;
    logic                          beat_last, tlast_q;
    logic                          tvalid_q, tvalid_d;
    logic                          tempty_q, tempty_d;

    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        full       = (count == ptr_t'(FIFO_LEN));
        wr_en      = s_axis_in_tvalid && !full;
        beat_avail = (count >= ptr_t'(OUT_MUX)) || (last_cnt_q != '0);
        load       = beat_avail && (!tvalid_q || m_axis_out_tready);
    end

    // Gather the window from rd_ptr, stopping after the first stored tlast.
    always_comb begin
        beat_data = '0;
        beat_user = '0;
        beat_keep = '0;
        beat_last = 1'b0;
        beat_len  = ptr_t'(OUT_MUX);
        found     = 1'b0;
        rd_addr   = '0;
        for (int unsigned i = 0; i < OUT_MUX; i++) begin
            rd_addr = rd_ptr_q[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
            if (!found) begin
                beat_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_data[rd_addr];
                beat_user[i*USER_WIDTH +: USER_WIDTH] = mem_user[rd_addr];
                beat_keep[i] = 1'b1;
                if (mem_last[rd_addr] && (ptr_t'(i) < count)) begin
                    found     = 1'b1;
                    beat_last = 1'b1;
                    beat_len  = ptr_t'(i + 1);
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ptr_t'(wr_en);
        rd_ptr_d   = load ? rd_ptr_q + beat_len : rd_ptr_q;
        last_cnt_d = last_cnt_q + ptr_t'(wr_en && s_axis_in_tlast) - ptr_t'(load && beat_last);
        if (load) begin
            tvalid_d = 1'b1;
        end else if (m_axis_out_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
        tempty_d = (wr_ptr_d == rd_ptr_d) && !tvalid_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tempty_q   <= 1'b1;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_cnt_q <= last_cnt_d;
            tvalid_q   <= tvalid_d;
            tempty_q   <= tempty_d;
            if (load) begin
                tdata_q <= beat_data;
                tuser_q <= beat_user;
                tkeep_q <= beat_keep;
                tlast_q <= beat_last;
            end
        end
    end

    // Storage contents are never reset; pointers and last_cnt define what is live.
    always_ff @(posedge clk_i) begin
        if (wr_en && !reset_i) begin
            mem_data[wr_ptr_q[PTR_WIDTH-1:0]] <= s_axis_in_tdata;
            mem_user[wr_ptr_q[PTR_WIDTH-1:0]] <= s_axis_in_tuser;
            mem_last[wr_ptr_q[PTR_WIDTH-1:0]] <= s_axis_in_tlast;
        end
    end

    assign s_axis_in_tready  = !full;
    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tuser  = tuser_q;
    assign m_axis_out_tkeep  = tkeep_q;
    assign m_axis_out_tlast  = tlast_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign m_axis_out_tempty = tempty_q;

`ifdef AXIS_PACK_FIFO_LEVEL_EN
    ptr_t level_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q <= '0;
        end else begin
            level_q <= wr_ptr_d - rd_ptr_d;
        end
    end

    assign m_axis_out_tlevel = level_q;
`endif

endmodule
